// File: rtl/gz_seq_ctrl.sv
// Round-robin scheduler that time-shares one Goertzel engine across NCH ADC channels.
// Each window: clear engine, feed N samples at half rate, await result, emit it, update detect bit.
module gz_seq_ctrl #(
   parameter int NCH     = 4,
   parameter int N       = 126,
   parameter int IW      = 12,
   parameter int OW      = 20,
   parameter int SW      = 16,
   parameter int TIMEOUT = 512
) (
   input  logic              aclk,
   input  logic              arst,
   input  logic              start_en,
   input  logic [NCH-1:0]    ch_mask,
   input  logic [32:0]       lower_thr,
   input  logic [32:0]       upper_thr,
   input  logic [NCH-1:0]    s_tvalid,
   input  logic [NCH*IW-1:0] s_tdata,
   output logic              gz_rst,
   output logic              gz_clken,
   output logic [IW-1:0]     gz_tdata,
   output logic              gz_tvalid,
   input  logic [2*OW-1:0]   gz_result,
   input  logic              gz_result_valid,
   output logic              gz_result_ready,
   output logic [127:0]      m_axis_tdata,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic [NCH-1:0]    signal_detected,
   output logic [1:0]        cur_ch,
   output logic              busy,
   output logic              timeout_err
);

   localparam int CW = $clog2(N + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, SELECT, CLEAR, FEED, WAIT, EMIT} state_t;

   state_t                 state;
   logic [1:0]             last_ch;
   logic [1:0]             nxt_ch;
   logic                   found;
   logic [CW-1:0]          cnt;
   logic [TW-1:0]          wcnt;
   logic signed [SW-1:0]   re, im, re_n, im_n;
   logic signed [2*SW-1:0] re_sq, im_sq;
   logic [32:0]            mag_sq;
   logic                   unused_lsb;

   // Search order starts just after the last served channel and wraps.
   always_comb begin
      nxt_ch = last_ch;
      found  = 1'b0;
      for (int i = 1; i <= NCH; i++) begin
         if (!found && ch_mask[(int'(last_ch) + i) % NCH]) begin
            nxt_ch = 2'((int'(last_ch) + i) % NCH);
            found  = 1'b1;
         end
      end
   end

   assign re_n       = gz_result[2*OW-1 -: SW];
   assign im_n       = gz_result[OW-1 -: SW];
   assign re_sq      = re_n * re_n;
   assign im_sq      = im_n * im_n;
   assign unused_lsb = ^{gz_result[2*OW-SW-1:OW], gz_result[OW-SW-1:0]};

   assign busy            = (state != IDLE);
   assign gz_result_ready = (state == WAIT);
   assign m_axis_tvalid   = (state == EMIT);
   assign gz_tvalid       = (state == FEED) && gz_clken && s_tvalid[cur_ch];
   assign gz_tdata        = (state == FEED) ? s_tdata[int'(cur_ch)*IW +: IW] : '0;
   assign m_axis_tdata    = m_axis_tvalid ? {{(126-2*SW){1'b0}}, cur_ch, re, im} : '0;

   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         state           <= IDLE;
         last_ch         <= 2'(NCH - 1);
         cur_ch          <= 2'd0;
         cnt             <= '0;
         wcnt            <= '0;
         re              <= '0;
         im              <= '0;
         mag_sq          <= '0;
         gz_rst          <= 1'b0;
         gz_clken        <= 1'b0;
         signal_detected <= '0;
         timeout_err     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_en && (ch_mask != '0)) state <= SELECT;
            end
            SELECT: begin
               if (!found) begin
                  state <= IDLE;
               end else begin
                  cur_ch  <= nxt_ch;
                  last_ch <= nxt_ch;
                  gz_rst  <= 1'b1;
                  state   <= CLEAR;
               end
            end
            CLEAR: begin
               gz_rst   <= 1'b0;
               cnt      <= '0;
               gz_clken <= 1'b1;
               state    <= FEED;
            end
            FEED: begin
               gz_clken <= ~gz_clken;
               if (gz_tvalid) begin
                  cnt <= cnt + 1'b1;
                  if (cnt == CW'(N - 1)) begin
                     wcnt  <= '0;
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               gz_clken <= ~gz_clken;
               if (gz_result_valid) begin
                  re       <= re_n;
                  im       <= im_n;
                  mag_sq   <= {1'b0, re_sq} + {1'b0, im_sq};
                  gz_clken <= 1'b0;
                  state    <= EMIT;
               end else if (wcnt == TW'(TIMEOUT - 1)) begin
                  // Engine never answered: drop the window and move on.
                  timeout_err             <= 1'b1;
                  signal_detected[cur_ch] <= 1'b0;
                  gz_clken                <= 1'b0;
                  state                   <= start_en ? SELECT : IDLE;
               end else begin
                  wcnt <= wcnt + 1'b1;
               end
            end
            EMIT: begin
               if (m_axis_tready) begin
                  signal_detected[cur_ch] <= (mag_sq > lower_thr) && (mag_sq < upper_thr);
                  state                   <= start_en ? SELECT : IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gz_seq_ctrl.sv
// Directed bench for gz_seq_ctrl: round-robin windows, detection band, backpressure,
// engine timeout, reset mid-window, and gapped input with start_en dropped mid-window.
module tb_gz_seq_ctrl;

   localparam int NCH = 4, N = 126, IW = 12, OW = 20, SW = 16, TIMEOUT = 512;

   logic              aclk = 1'b0;
   logic              arst;
   logic              start_en;
   logic [NCH-1:0]    ch_mask;
   logic [32:0]       lower_thr, upper_thr;
   logic [NCH-1:0]    s_tvalid;
   logic [NCH*IW-1:0] s_tdata;
   logic              gz_rst, gz_clken, gz_tvalid, gz_result_ready;
   logic [IW-1:0]     gz_tdata;
   logic [2*OW-1:0]   gz_result;
   logic              gz_result_valid = 1'b0;
   logic [127:0]      m_axis_tdata;
   logic              m_axis_tvalid, m_axis_tready;
   logic [NCH-1:0]    signal_detected;
   logic [1:0]        cur_ch;
   logic              busy, timeout_err;

   int n_chk = 0, n_fail = 0;
   int acc_total = 0, rst_total = 0, emit_total = 0, tv_total = 0;
   int win_acc = 0, lat = -1, phase = 0;
   logic resp_en = 1'b0, gap_mode = 1'b0;

   gz_seq_ctrl #(.NCH(NCH), .N(N), .IW(IW), .OW(OW), .SW(SW), .TIMEOUT(TIMEOUT)) dut (
      .aclk(aclk), .arst(arst), .start_en(start_en), .ch_mask(ch_mask),
      .lower_thr(lower_thr), .upper_thr(upper_thr), .s_tvalid(s_tvalid), .s_tdata(s_tdata),
      .gz_rst(gz_rst), .gz_clken(gz_clken), .gz_tdata(gz_tdata), .gz_tvalid(gz_tvalid),
      .gz_result(gz_result), .gz_result_valid(gz_result_valid), .gz_result_ready(gz_result_ready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .signal_detected(signal_detected), .cur_ch(cur_ch), .busy(busy), .timeout_err(timeout_err)
   );

   always #5 aclk = ~aclk;

   // Engine model and event counters, sampled at the active edge.
   always @(posedge aclk) begin
      if (gz_rst) begin
         rst_total++;
         win_acc = 0;
         lat = -1;
      end
      if (gz_tvalid) begin
         acc_total++;
         win_acc++;
         if (win_acc == N) lat = 10;
      end else if (lat > 0) begin
         lat--;
      end
      if (gz_result_valid && gz_result_ready) lat = -1;
      if (m_axis_tvalid) tv_total++;
      if (m_axis_tvalid && m_axis_tready) emit_total++;
   end

   always @(negedge aclk) begin
      gz_result_valid = resp_en && (lat == 0);
      phase++;
      s_tvalid = (!gap_mode || (phase % 3 == 0)) ? 4'hF : 4'h0;
   end

   function automatic logic [2*OW-1:0] mk_res(input logic [15:0] r, input logic [15:0] i);
      return {r, 4'h0, i, 4'h0};
   endfunction

   function automatic logic [127:0] exp_td(input logic [1:0] ch, input logic [15:0] r, input logic [15:0] i);
      return {94'd0, ch, r, i};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic cond(input int w);
      case (w)
         0:       return gz_rst;
         1:       return m_axis_tvalid;
         2:       return gz_result_ready;
         default: return !busy;
      endcase
   endfunction

   task automatic wait_for(input int w, input int budget, input string tag);
      int n = 0;
      while (!cond(w) && n < budget) begin
         @(negedge aclk);
         n++;
      end
      chk(tag, 128'(cond(w)), 128'd1);
   endtask

   initial begin
      int acc0, rst0, emit0, tv0, n, wcyc;
      logic [127:0] td;
      logic stable;

      arst = 1'b1; start_en = 1'b0; ch_mask = '0; m_axis_tready = 1'b1;
      lower_thr = 33'd65_028_096; upper_thr = 33'd67_108_864;
      s_tdata = {12'h0A3, 12'h0A2, 12'h0A1, 12'h0A0};
      gz_result = mk_res(16'd8100, 16'd0);
      resp_en = 1'b1;
      repeat (3) @(negedge aclk);
      chk("rst_ctrl", 128'({busy, gz_clken, gz_rst, gz_tvalid, gz_result_ready, m_axis_tvalid, timeout_err}), 128'd0);
      chk("rst_det_ch", 128'({signal_detected, cur_ch}), 128'd0);
      chk("rst_data", 128'({m_axis_tdata, gz_tdata}), 128'd0);
      arst = 1'b0;
      @(negedge aclk);

      // Window 1: ch0, re=8100 falls inside the band.
      ch_mask = 4'b0101; start_en = 1'b1;
      wait_for(0, 10, "w1_clear");
      acc0 = acc_total; rst0 = rst_total;
      chk("w1_ch", 128'(cur_ch), 128'd0);
      @(negedge aclk);
      chk("w1_feed1", 128'({gz_clken, gz_tvalid, gz_tdata}), 128'({2'b11, 12'h0A0}));
      @(negedge aclk);
      chk("w1_feed2", 128'({gz_clken, gz_tvalid}), 128'd0);
      wait_for(1, 400, "w1_emit");
      chk("w1_accepts", 128'(acc_total - acc0), 128'(N));
      chk("w1_rst_pulses", 128'(rst_total - rst0), 128'd1);
      chk("w1_tdata", m_axis_tdata, exp_td(2'd0, 16'd8100, 16'd0));
      @(negedge aclk);
      chk("w1_det", 128'(signal_detected), 128'h1);

      // Window 2: ch2, same result.
      wait_for(0, 10, "w2_clear");
      chk("w2_ch", 128'(cur_ch), 128'd2);
      wait_for(1, 400, "w2_emit");
      chk("w2_tdata", m_axis_tdata, exp_td(2'd2, 16'd8100, 16'd0));
      gz_result = mk_res(16'd8200, 16'd0);
      @(negedge aclk);
      chk("w2_det", 128'(signal_detected), 128'h5);
      m_axis_tready = 1'b0;

      // Window 3: ch0 again, re=8200 above band, sink stalls 10 cycles.
      wait_for(0, 10, "w3_clear");
      chk("w3_ch", 128'(cur_ch), 128'd0);
      wait_for(1, 400, "w3_emit");
      td = m_axis_tdata; rst0 = rst_total; stable = 1'b1;
      chk("w3_tdata", td, exp_td(2'd0, 16'd8200, 16'd0));
      repeat (10) begin
         @(negedge aclk);
         if (!(m_axis_tvalid && m_axis_tdata === td && !gz_rst)) stable = 1'b0;
      end
      chk("w3_hold_stable", 128'(stable), 128'd1);
      chk("w3_no_clear", 128'(rst_total - rst0), 128'd0);
      m_axis_tready = 1'b1;
      resp_en = 1'b0;
      @(negedge aclk);
      chk("w3_det", 128'({m_axis_tvalid, signal_detected}), 128'h4);

      // Window 4: ch2, engine never answers.
      wait_for(0, 10, "w4_clear");
      chk("w4_ch", 128'(cur_ch), 128'd2);
      tv0 = tv_total;
      wait_for(2, 400, "w4_wait");
      wcyc = 1; n = 0;
      while (gz_result_ready && n < 700) begin
         @(negedge aclk);
         n++;
         if (gz_result_ready) wcyc++;
      end
      chk("w4_wait_cycles", 128'(wcyc), 128'(TIMEOUT));
      chk("w4_timeout_err", 128'(timeout_err), 128'd1);
      chk("w4_det", 128'(signal_detected), 128'h0);
      chk("w4_no_emit", 128'(tv_total - tv0), 128'd0);
      wait_for(0, 10, "w5_clear");
      chk("w5_ch", 128'(cur_ch), 128'd0);

      // Window 5: reset asserted at the 60th accept.
      resp_en = 1'b1;
      gz_result = mk_res(16'd100, 16'hFFCE);
      acc0 = acc_total; n = 0;
      while (acc_total - acc0 < 59 && n < 400) begin
         @(negedge aclk);
         n++;
      end
      while (!gz_tvalid && n < 400) begin
         @(negedge aclk);
         n++;
      end
      chk("w5_at_60th", 128'(acc_total - acc0), 128'd59);
      arst = 1'b1;
      #1;
      chk("w5_rst_ctrl", 128'({busy, gz_clken, gz_rst, gz_tvalid, gz_result_ready, m_axis_tvalid, timeout_err}), 128'd0);
      chk("w5_rst_det_ch", 128'({signal_detected, cur_ch, gz_tdata}), 128'd0);
      ch_mask = 4'b1000;
      @(negedge aclk);
      arst = 1'b0;
      wait_for(0, 10, "w6_clear");
      chk("w6_ch", 128'(cur_ch), 128'd3);
      wait_for(1, 400, "w6_emit");
      chk("w6_tdata", m_axis_tdata, exp_td(2'd3, 16'd100, 16'hFFCE));
      gap_mode = 1'b1;
      @(negedge aclk);
      chk("w6_det", 128'(signal_detected), 128'h0);

      // Window 7: gapped samples, start_en dropped mid-feed.
      wait_for(0, 10, "w7_clear");
      acc0 = acc_total; rst0 = rst_total; emit0 = emit_total;
      chk("w7_ch", 128'(cur_ch), 128'd3);
      repeat (100) @(negedge aclk);
      start_en = 1'b0;
      chk("w7_busy_mid", 128'(busy), 128'd1);
      wait_for(1, 1500, "w7_emit");
      chk("w7_accepts", 128'(acc_total - acc0), 128'(N));
      wait_for(3, 10, "w7_idle");
      chk("w7_one_emit", 128'(emit_total - emit0), 128'd1);
      repeat (20) @(negedge aclk);
      chk("w7_stays_idle", 128'({busy, 8'(rst_total - rst0)}), 128'h001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
